// File: rtl/memory_port_arbiter_if.sv
// Bundle of requester, backing-memory and peripheral signals for the arbiter.
// The slave modport is the arbiter itself.
// The master modport is the surrounding system.
// That system is the requesters plus the two memory-side ports.
interface memory_port_arbiter_if #(
   parameter int CHANNELS   = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [CHANNELS-1:0]            req_valid;
   logic [CHANNELS-1:0]            req_write;
   logic [CHANNELS*ADDR_WIDTH-1:0] req_addr;
   logic [CHANNELS*DATA_WIDTH-1:0] req_wdata;
   logic [CHANNELS-1:0]            resp_ready;
   logic [CHANNELS*DATA_WIDTH-1:0] resp_rdata;

   logic                  mem_read_enable;
   logic                  mem_write_enable;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_data_out;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic                  mem_ready;

   logic                  periph_read_enable;
   logic                  periph_write_enable;
   logic [ADDR_WIDTH-1:0] periph_address;
   logic [DATA_WIDTH-1:0] periph_data_out;
   logic [DATA_WIDTH-1:0] periph_data_in;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output resp_ready, resp_rdata,
      output mem_read_enable, mem_write_enable, mem_address, mem_data_out,
      input  mem_data_in, mem_ready,
      output periph_read_enable, periph_write_enable, periph_address, periph_data_out,
      input  periph_data_in
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  resp_ready, resp_rdata,
      input  mem_read_enable, mem_write_enable, mem_address, mem_data_out,
      output mem_data_in, mem_ready,
      input  periph_read_enable, periph_write_enable, periph_address, periph_data_out,
      output periph_data_in
   );
endinterface

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter that funnels CHANNELS requesters onto one
// variable-latency backing-memory port and one single-cycle peripheral port.
// The port is chosen by matching an address prefix.
module memory_port_arbiter #(
   parameter int          CHANNELS           = 2,
   parameter int          ADDR_WIDTH         = 32,
   parameter int          DATA_WIDTH         = 32,
   parameter int          PERIPH_PREFIX_BITS = 1,
   parameter int unsigned PERIPH_PREFIX      = 1
) (
   input logic                 clk,
   input logic                 reset,
   memory_port_arbiter_if.slave bus
);
   localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [PERIPH_PREFIX_BITS-1:0] PREFIX_VAL = PERIPH_PREFIX_BITS'(PERIPH_PREFIX);

   typedef enum logic [1:0] {IDLE, MEM_WAIT, PERIPH, RESPOND} stateT;

   stateT                          state, stateNext;
   logic [PTR_W-1:0]               rrPtr;
   logic [PTR_W-1:0]               grantIdx;
   logic [ADDR_WIDTH-1:0]          latAddr;
   logic                           latWrite;
   logic [DATA_WIDTH-1:0]          latWdata;
   logic [CHANNELS*DATA_WIDTH-1:0] respRdata;

   logic                  anyReq;
   logic                  found;
   logic [PTR_W-1:0]      candIdx;
   logic [PTR_W-1:0]      pickIdx;
   logic [ADDR_WIDTH-1:0] pickAddr;
   logic                  pickPeriph;

   // Round-robin pick: first requesting channel at or above rrPtr, wrapping
   // around, plus the port decode of the winner's address.
   always_comb begin
      anyReq  = |bus.req_valid;
      found   = 1'b0;
      candIdx = '0;
      pickIdx = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         candIdx = PTR_W'((int'(rrPtr) + i) % CHANNELS);
         if (!found && bus.req_valid[candIdx]) begin
            pickIdx = candIdx;
            found   = 1'b1;
         end
      end
      pickAddr   = bus.req_addr[int'(pickIdx)*ADDR_WIDTH +: ADDR_WIDTH];
      pickPeriph = (pickAddr[ADDR_WIDTH-1 -: PERIPH_PREFIX_BITS] == PREFIX_VAL);
   end

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   // Next-state logic and all port strobes. Every output is 0 outside the
   // state that owns it.
   always_comb begin
      stateNext               = state;
      bus.mem_read_enable     = 1'b0;
      bus.mem_write_enable    = 1'b0;
      bus.mem_address         = '0;
      bus.mem_data_out        = '0;
      bus.periph_read_enable  = 1'b0;
      bus.periph_write_enable = 1'b0;
      bus.periph_address      = '0;
      bus.periph_data_out     = '0;
      bus.resp_ready          = '0;
      case (state)
         IDLE: begin
            if (anyReq) stateNext = pickPeriph ? PERIPH : MEM_WAIT;
         end
         MEM_WAIT: begin
            bus.mem_read_enable  = !latWrite;
            bus.mem_write_enable = latWrite;
            bus.mem_address      = latAddr;
            bus.mem_data_out     = latWdata;
            if (bus.mem_ready) stateNext = RESPOND;
         end
         PERIPH: begin
            bus.periph_read_enable  = !latWrite;
            bus.periph_write_enable = latWrite;
            bus.periph_address      = latAddr;
            bus.periph_data_out     = latWdata;
            stateNext               = RESPOND;
         end
         RESPOND: begin
            bus.resp_ready = CHANNELS'(1) << grantIdx;
            stateNext      = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Grant bookkeeping, request latching and per-channel read-data capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         rrPtr     <= '0;
         grantIdx  <= '0;
         latAddr   <= '0;
         latWrite  <= 1'b0;
         latWdata  <= '0;
         respRdata <= '0;
      end else begin
         if (state == IDLE && anyReq) begin
            grantIdx <= pickIdx;
            latAddr  <= pickAddr;
            latWrite <= bus.req_write[pickIdx];
            latWdata <= bus.req_wdata[int'(pickIdx)*DATA_WIDTH +: DATA_WIDTH];
            rrPtr    <= PTR_W'((int'(pickIdx) + 1) % CHANNELS);
         end
         if (state == MEM_WAIT && bus.mem_ready && !latWrite)
            respRdata[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_data_in;
         if (state == PERIPH && !latWrite)
            respRdata[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH] <= bus.periph_data_in;
      end
   end

   assign bus.resp_rdata = respRdata;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter.
// Instance A is the default two-channel build.
// Instance B has four channels and a 2-bit peripheral prefix of 2'b11.
module tb_memory_port_arbiter;
   logic clk;
   logic reset;
   int   compared;
   int   mismatched;

   memory_port_arbiter_if #(.CHANNELS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) busA ();
   memory_port_arbiter_if #(.CHANNELS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) busB ();

   memory_port_arbiter #(
      .CHANNELS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .PERIPH_PREFIX_BITS(1), .PERIPH_PREFIX(1)
   ) dutA (.clk(clk), .reset(reset), .bus(busA.slave));

   memory_port_arbiter #(
      .CHANNELS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .PERIPH_PREFIX_BITS(2), .PERIPH_PREFIX(3)
   ) dutB (.clk(clk), .reset(reset), .bus(busB.slave));

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives the request valid/write vectors of instance A.
   task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] write);
      busA.req_valid = valid;
      busA.req_write = write;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      applyStimulus(2'b00, 2'b00);
      busA.req_addr = '0;  busA.req_wdata = '0;
      busA.mem_data_in = '0; busA.mem_ready = 1'b0; busA.periph_data_in = '0;
      busB.req_valid = '0; busB.req_write = '0; busB.req_addr = '0; busB.req_wdata = '0;
      busB.mem_data_in = '0; busB.mem_ready = 1'b0; busB.periph_data_in = '0;
      tick();
      tick();

      // Reset state of both instances
      checkOutput("rstMemRd",    busA.mem_read_enable, 0);
      checkOutput("rstPerWr",    busA.periph_write_enable, 0);
      checkOutput("rstRespRdy",  busA.resp_ready, 0);
      checkOutput("rstRdata",    busA.resp_rdata, 0);
      checkOutput("rstMemAddr",  busA.mem_address, 0);
      checkOutput("rstPerAddr",  busA.periph_address, 0);
      checkOutput("rstBRespRdy", busB.resp_ready, 0);
      reset = 1'b0;

      // Single memory read, mem_ready on third MEM_WAIT cycle
      applyStimulus(2'b01, 2'b00);
      busA.req_addr[31:0] = 32'h0000_0040;
      tick();
      checkOutput("rdC1MemRd",  busA.mem_read_enable, 1);
      checkOutput("rdC1MemWr",  busA.mem_write_enable, 0);
      checkOutput("rdC1Addr",   busA.mem_address, 32'h40);
      checkOutput("rdC1PerRd",  busA.periph_read_enable, 0);
      tick();
      checkOutput("rdC2MemRd",  busA.mem_read_enable, 1);
      checkOutput("rdC2Rdy",    busA.resp_ready, 0);
      tick();
      checkOutput("rdC3MemRd",  busA.mem_read_enable, 1);
      busA.mem_ready   = 1'b1;
      busA.mem_data_in = 32'hDEAD_BEEF;
      tick();
      checkOutput("rdC4Rdy",    busA.resp_ready, 2'b01);
      checkOutput("rdC4MemRd",  busA.mem_read_enable, 0);
      checkOutput("rdC4Rdata",  busA.resp_rdata[31:0], 32'hDEAD_BEEF);
      busA.mem_ready = 1'b0;
      tick();
      checkOutput("rdC5Rdy",    busA.resp_ready, 0);

      // Peripheral write from channel 1
      applyStimulus(2'b10, 2'b10);
      busA.req_addr[63:32]  = 32'h8000_0000;
      busA.req_wdata[63:32] = 32'h0000_003F;
      busA.periph_data_in   = 32'h1234_5678;
      tick();
      checkOutput("pwWr",       busA.periph_write_enable, 1);
      checkOutput("pwRd",       busA.periph_read_enable, 0);
      checkOutput("pwAddr",     busA.periph_address, 32'h8000_0000);
      checkOutput("pwData",     busA.periph_data_out, 32'h3F);
      checkOutput("pwMemRd",    busA.mem_read_enable, 0);
      checkOutput("pwMemWr",    busA.mem_write_enable, 0);
      checkOutput("pwMemAddr",  busA.mem_address, 0);
      tick();
      checkOutput("pwRdy",      busA.resp_ready, 2'b10);
      checkOutput("pwWrOff",    busA.periph_write_enable, 0);
      checkOutput("pwRdata1",   busA.resp_rdata[63:32], 0);
      tick();

      // Peripheral read on channel 1 captures periph_data_in
      applyStimulus(2'b10, 2'b00);
      busA.req_addr[63:32] = 32'h8000_0010;
      busA.periph_data_in  = 32'hCAFE_F00D;
      tick();
      checkOutput("prRd",       busA.periph_read_enable, 1);
      checkOutput("prAddr",     busA.periph_address, 32'h8000_0010);
      tick();
      checkOutput("prRdy",      busA.resp_ready, 2'b10);
      checkOutput("prRdata1",   busA.resp_rdata[63:32], 32'hCAFE_F00D);
      checkOutput("prRdata0",   busA.resp_rdata[31:0], 32'hDEAD_BEEF);
      tick();

      // Fairness: both channels read continuously, mem_ready tied high
      applyStimulus(2'b11, 2'b00);
      busA.req_addr[31:0]  = 32'h0000_0100;
      busA.req_addr[63:32] = 32'h0000_0200;
      busA.mem_ready       = 1'b1;
      for (int t = 0; t < 4; t++) begin
         tick();
         checkOutput("fairAddr", busA.mem_address, (t % 2 == 0) ? 32'h100 : 32'h200);
         busA.mem_data_in = 32'h1000 + t;
         tick();
         checkOutput("fairRdy", busA.resp_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
         checkOutput("fairRdata", busA.resp_rdata[(t % 2)*32 +: 32], 32'h1000 + t);
         tick();
      end

      // Back-to-back reads on channel 0 with no bubble
      applyStimulus(2'b01, 2'b00);
      busA.req_addr[31:0] = 32'h0000_0300;
      busA.mem_data_in    = 32'h1111_1111;
      tick();
      checkOutput("b2bAddr1",   busA.mem_address, 32'h300);
      tick();
      checkOutput("b2bRdy1",    busA.resp_ready, 2'b01);
      checkOutput("b2bRdata1",  busA.resp_rdata[31:0], 32'h1111_1111);
      tick();
      busA.req_addr[31:0] = 32'h0000_0304;
      busA.mem_data_in    = 32'h2222_2222;
      tick();
      checkOutput("b2bAddr2",   busA.mem_address, 32'h304);
      tick();
      checkOutput("b2bRdata2",  busA.resp_rdata[31:0], 32'h2222_2222);
      applyStimulus(2'b00, 2'b00);
      tick();

      // Reset while channel 0 waits in MEM_WAIT
      applyStimulus(2'b01, 2'b00);
      busA.req_addr[31:0] = 32'h0000_0400;
      busA.mem_ready      = 1'b0;
      tick();
      checkOutput("rmwMemRd",   busA.mem_read_enable, 1);
      reset = 1'b1;
      tick();
      checkOutput("rmwStrobe",  busA.mem_read_enable, 0);
      checkOutput("rmwRdy",     busA.resp_ready, 0);
      checkOutput("rmwRdata",   busA.resp_rdata, 0);
      reset = 1'b0;
      applyStimulus(2'b11, 2'b00);
      busA.req_addr[63:32] = 32'h0000_0500;
      tick();
      checkOutput("rmwPtr0",    busA.mem_address, 32'h400);
      busA.mem_ready   = 1'b1;
      busA.mem_data_in = 32'h4444_4444;
      tick();
      checkOutput("rmwRdyAfter", busA.resp_ready, 2'b01);
      checkOutput("rmwRdata0",  busA.resp_rdata[31:0], 32'h4444_4444);
      applyStimulus(2'b00, 2'b00);
      tick();

      // Memory write on channel 1 leaves its rdata untouched
      applyStimulus(2'b10, 2'b10);
      busA.req_addr[63:32]  = 32'h0000_0600;
      busA.req_wdata[63:32] = 32'h0000_ABCD;
      busA.mem_data_in      = 32'h9999_9999;
      tick();
      checkOutput("mwWr",       busA.mem_write_enable, 1);
      checkOutput("mwRd",       busA.mem_read_enable, 0);
      checkOutput("mwAddr",     busA.mem_address, 32'h600);
      checkOutput("mwData",     busA.mem_data_out, 32'hABCD);
      tick();
      checkOutput("mwRdy",      busA.resp_ready, 2'b10);
      checkOutput("mwRdata1",   busA.resp_rdata[63:32], 0);
      applyStimulus(2'b00, 2'b00);
      busA.mem_ready = 1'b0;
      tick();

      // Four channels: ch2 (memory) beats ch3 (peripheral) from rrPtr 0
      busB.req_valid          = 4'b1100;
      busB.req_addr[127:96]   = 32'hC000_0004;
      busB.req_addr[95:64]    = 32'h8000_0000;
      busB.periph_data_in     = 32'h3333_3333;
      tick();
      checkOutput("b4MemRd",    busB.mem_read_enable, 1);
      checkOutput("b4MemAddr",  busB.mem_address, 32'h8000_0000);
      checkOutput("b4PerRd",    busB.periph_read_enable, 0);
      busB.mem_ready   = 1'b1;
      busB.mem_data_in = 32'h2222_0000;
      tick();
      checkOutput("b4Rdy2",     busB.resp_ready, 4'b0100);
      checkOutput("b4Rdata2",   busB.resp_rdata[95:64], 32'h2222_0000);
      tick();
      busB.req_valid = 4'b1000;
      tick();
      checkOutput("b4PerRd3",   busB.periph_read_enable, 1);
      checkOutput("b4PerAddr",  busB.periph_address, 32'hC000_0004);
      checkOutput("b4MemRd3",   busB.mem_read_enable, 0);
      tick();
      checkOutput("b4Rdy3",     busB.resp_ready, 4'b1000);
      checkOutput("b4Rdata3",   busB.resp_rdata[127:96], 32'h3333_3333);
      busB.req_valid = 4'b0000;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
